draw_sweep_bar: RTL

- Rendering stage between draw_background and MouseDisplay in the pclk video chain.
- Takes the background's delayed timing and RGB, overlays a horizontal "laser" bar, and forwards everything one cycle later.
- The bar first shows a warning phase, then sweeps top-to-bottom across the arena once per trigger.
- Checks the cursor position against the bar each frame and reports hits and sweep completion to game logic.

---
 rtl/game_pkg.sv | 29 ++
 rtl/frame_tick_gen.sv | 24 ++
 rtl/draw_sweep_bar.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared arena geometry, colours and sweep-bar FSM states.
// Imported by draw_sweep_bar and the later obstacle stages.
package game_pkg;

  localparam logic [11:0] TOP_V_LINE    = 12'd367;
  localparam logic [11:0] BOTTOM_V_LINE = 12'd667;
  localparam logic [11:0] LEFT_H_LINE   = 12'd361;
  localparam logic [11:0] RIGHT_H_LINE  = 12'd661;

  localparam logic [11:0] BAR_COLOR  = 12'hF00;
  localparam logic [11:0] WARN_COLOR = 12'h840;

  typedef enum logic [1:0] {
    IDLE,
    WARN,
    SWEEP,
    DONE
  } bar_state_e;

  // Inclusive range test, widened so bounds never wrap.
  function automatic logic in_span(
    input logic [12:0] val,
    input logic [12:0] lo,
    input logic [12:0] hi
  );
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame strobe, registered one cycle after the
// raster origin (hcount==0, vcount==0) is seen.
module frame_tick_gen (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] hcount_i,
  input  logic [11:0] vcount_i,
  output logic        tick_o
);

  logic tick_q;

  // Register the origin detect so the strobe is glitch-free.
  always_ff @(posedge pclk) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= (hcount_i == 12'd0) && (vcount_i == 12'd0);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/draw_sweep_bar.sv
// Laser-bar overlay: warning phase, then a top-to-bottom sweep,
// with per-frame cursor collision and a one-cycle pipeline delay.
module draw_sweep_bar
  import game_pkg::*;
#(
  parameter int unsigned BAR_H       = 10,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned WARN_FRAMES = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        start,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        hit,
  output logic        done,
  output logic        busy
);

  localparam int unsigned WW = $clog2(WARN_FRAMES + 1);
  localparam logic [12:0] END_ROW =
    {1'b0, BOTTOM_V_LINE} - 13'(BAR_H) + 13'd1;
  localparam logic [12:0] X_LO = {1'b0, LEFT_H_LINE};
  localparam logic [12:0] X_HI = {1'b0, RIGHT_H_LINE};

  bar_state_e    state_q, state_d;
  logic [11:0]   bar_y_q, bar_y_d;
  logic [WW-1:0] warn_cnt_q, warn_cnt_d;
  logic          hit_q;
  logic          tick;

  logic [12:0] bar_top;
  logic [12:0] bar_bot;
  logic [12:0] bar_next;
  logic        active;
  logic        pix_in_bar;
  logic        cur_in_bar;
  logic        hit_d;
  logic [11:0] rgb_d;

  frame_tick_gen u_tick (
    .pclk     (pclk),
    .rst      (rst),
    .hcount_i (hcount_in),
    .vcount_i (vcount_in),
    .tick_o   (tick)
  );

  assign bar_top  = {1'b0, bar_y_q};
  assign bar_bot  = bar_top + 13'(BAR_H - 1);
  assign bar_next = bar_top + 13'(SPEED);
  assign active   = (state_q == WARN) || (state_q == SWEEP);

  assign pix_in_bar =
    in_span({1'b0, vcount_in}, bar_top, bar_bot) &&
    in_span({1'b0, hcount_in}, X_LO, X_HI);

  assign cur_in_bar =
    in_span({1'b0, ypos}, bar_top, bar_bot) &&
    in_span({1'b0, xpos}, X_LO, X_HI);

  // Collision uses bar_y before this tick moves it.
  assign hit_d = tick && (state_q == SWEEP) && cur_in_bar;

  // Next state, bar row and warning count; all motion on tick only.
  always_comb begin
    state_d    = state_q;
    bar_y_d    = bar_y_q;
    warn_cnt_d = warn_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WARN;
          bar_y_d    = TOP_V_LINE;
          warn_cnt_d = '0;
        end
      end
      WARN: begin
        if (tick) begin
          warn_cnt_d = warn_cnt_q + WW'(1);
          if (warn_cnt_q == WW'(WARN_FRAMES - 1)) begin
            state_d = SWEEP;
          end
        end
      end
      SWEEP: begin
        if (tick) begin
          if (bar_next > END_ROW) begin
            state_d = DONE;
          end else begin
            bar_y_d = bar_next[11:0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixel colour: blanking wins, then bar overlay, else pass-through.
  always_comb begin
    rgb_d = rgb_in;
    if (hblnk_in || vblnk_in) begin
      rgb_d = 12'h000;
    end else if (active && pix_in_bar) begin
      rgb_d = (state_q == WARN) ? WARN_COLOR : BAR_COLOR;
    end
  end

  // FSM and bar state registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= IDLE;
      bar_y_q    <= TOP_V_LINE;
      warn_cnt_q <= '0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bar_y_q    <= bar_y_d;
      warn_cnt_q <= warn_cnt_d;
      hit_q      <= hit_d;
    end
  end

  // One-cycle delay of timing and composited colour.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      hblnk_out  <= hblnk_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= rgb_d;
    end
  end

  assign hit  = hit_q;
  assign done = (state_q == DONE);
  assign busy = active;

endmodule
